// File: rtl/conv2d_tile_engine.sv
// conv2d_tile_engine: single-MAC 2-D convolution over one tile.
// A job snapshots its operands, streams OUT_DIM^2*KSIZE^2 multiply-accumulates
// through a 3-stage pipeline, and requantises each finished pixel
// (shift, optional ReLU, saturation) into the registered result tile.
module conv2d_tile_engine #(
  parameter  int DATA_W  = 8,
  parameter  int KSIZE   = 3,
  parameter  int OUT_DIM = 4,
  parameter  int ACC_W   = 24,
  parameter  int OUT_W   = 16,
  localparam int IN_DIM  = OUT_DIM + KSIZE - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              signed_mode,
  input  logic              relu_en,
  input  logic [4:0]        shift,
  input  logic [DATA_W-1:0] input_tile [0:IN_DIM-1][0:IN_DIM-1],
  input  logic [DATA_W-1:0] kernel     [0:KSIZE-1][0:KSIZE-1],
  output logic [OUT_W-1:0]  c          [0:OUT_DIM-1][0:OUT_DIM-1],
  output logic              busy,
  output logic              done
);

  localparam int OW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int IW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int PW = 2 * DATA_W;

  // Clamp limits, one bit wider than the accumulator so unsigned sums compare correctly
  localparam logic signed [ACC_W:0] SMAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SMIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W:0] UMAX = {{(ACC_W-OUT_W+1){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic              busy_q, done_q;
  logic [OW-1:0]     i_q, j_q;
  logic [KW-1:0]     m_q, n_q;

  logic [DATA_W-1:0] snap_tile_q   [0:IN_DIM-1][0:IN_DIM-1];
  logic [DATA_W-1:0] snap_kernel_q [0:KSIZE-1][0:KSIZE-1];
  logic              snap_signed_q, snap_relu_q;
  logic [4:0]        snap_shift_q;

  logic              s1_v_q, s1_first_q, s1_last_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;
  logic [OW-1:0]     s1_i_q, s1_j_q;
  logic              s2_v_q, s2_first_q, s2_last_q;
  logic [PW-1:0]     prod_q;
  logic [OW-1:0]     s2_i_q, s2_j_q;
  logic              acc_v_q, acc_last_q;
  logic [ACC_W-1:0]  acc_q;
  logic [OW-1:0]     acc_i_q, acc_j_q;
  logic [OUT_W-1:0]  c_q [0:OUT_DIM-1][0:OUT_DIM-1];

  logic              n_max, m_max, j_max, i_max, accept;
  logic [IW-1:0]     row, col;
  logic [PW-1:0]     a_ext, b_ext, prod_d;
  logic [ACC_W-1:0]  prod_ext, acc_d;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W:0]   wide;
  logic [OUT_W-1:0]  wb_d;

  assign n_max  = (n_q == KW'(KSIZE - 1));
  assign m_max  = (m_q == KW'(KSIZE - 1));
  assign j_max  = (j_q == OW'(OUT_DIM - 1));
  assign i_max  = (i_q == OW'(OUT_DIM - 1));
  assign accept = (state_q == S_IDLE) && start;
  assign row    = IW'(i_q) + IW'(m_q);
  assign col    = IW'(j_q) + IW'(n_q);

  // Job sequencing: handshake, raster-order issue counters, drain detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      m_q     <= '0;
      n_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            i_q     <= '0;
            j_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
          end
        end
        S_RUN: begin
          n_q <= n_max ? '0 : n_q + 1'b1;
          if (n_max) begin
            m_q <= m_max ? '0 : m_q + 1'b1;
            if (m_max) begin
              j_q <= j_max ? '0 : j_q + 1'b1;
              if (j_max) i_q <= i_max ? '0 : i_q + 1'b1;
            end
          end
          if (n_max && m_max && j_max && i_max) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // The final pixel's sum sits in the accumulator; its c write and done share the next edge
          if (acc_v_q && acc_last_q && acc_i_q == OW'(OUT_DIM - 1) && acc_j_q == OW'(OUT_DIM - 1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Multiply, accumulate and requantise; unsigned multiply of extended operands gives the right low bits in both modes
  always_comb begin
    a_ext    = snap_signed_q ? {{DATA_W{s1_a_q[DATA_W-1]}}, s1_a_q} : {{DATA_W{1'b0}}, s1_a_q};
    b_ext    = snap_signed_q ? {{DATA_W{s1_b_q[DATA_W-1]}}, s1_b_q} : {{DATA_W{1'b0}}, s1_b_q};
    prod_d   = a_ext * b_ext;
    prod_ext = snap_signed_q ? {{(ACC_W-PW){prod_q[PW-1]}}, prod_q} : {{(ACC_W-PW){1'b0}}, prod_q};
    acc_d    = s2_first_q ? prod_ext : acc_q + prod_ext;
    if (snap_signed_q) shifted = $signed(acc_q) >>> snap_shift_q;
    else               shifted = $signed(acc_q >> snap_shift_q);
    wide = snap_signed_q ? {shifted[ACC_W-1], shifted} : {1'b0, shifted};
    if (snap_signed_q && snap_relu_q && wide[ACC_W]) wide = '0;
    wb_d = wide[OUT_W-1:0];
    if (snap_signed_q) begin
      if (wide > SMAX)      wb_d = SMAX[OUT_W-1:0];
      else if (wide < SMIN) wb_d = SMIN[OUT_W-1:0];
    end else if (wide > UMAX) begin
      wb_d = UMAX[OUT_W-1:0];
    end
  end

  // Operand snapshot, MAC pipeline and result-tile writeback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < IN_DIM; r++)
        for (int s = 0; s < IN_DIM; s++) snap_tile_q[r][s] <= '0;
      for (int r = 0; r < KSIZE; r++)
        for (int s = 0; s < KSIZE; s++) snap_kernel_q[r][s] <= '0;
      for (int r = 0; r < OUT_DIM; r++)
        for (int s = 0; s < OUT_DIM; s++) c_q[r][s] <= '0;
      snap_signed_q <= 1'b0;
      snap_relu_q   <= 1'b0;
      snap_shift_q  <= '0;
      s1_v_q <= 1'b0; s1_first_q <= 1'b0; s1_last_q <= 1'b0;
      s1_a_q <= '0;   s1_b_q <= '0;       s1_i_q <= '0; s1_j_q <= '0;
      s2_v_q <= 1'b0; s2_first_q <= 1'b0; s2_last_q <= 1'b0;
      prod_q <= '0;   s2_i_q <= '0;       s2_j_q <= '0;
      acc_v_q <= 1'b0; acc_last_q <= 1'b0; acc_q <= '0;
      acc_i_q <= '0;   acc_j_q <= '0;
    end else begin
      if (accept) begin
        snap_tile_q   <= input_tile;
        snap_kernel_q <= kernel;
        snap_signed_q <= signed_mode;
        snap_relu_q   <= relu_en;
        snap_shift_q  <= shift;
      end
      s1_v_q     <= (state_q == S_RUN);
      s1_a_q     <= snap_tile_q[row][col];
      s1_b_q     <= snap_kernel_q[m_q][n_q];
      s1_first_q <= (m_q == '0) && (n_q == '0);
      s1_last_q  <= m_max && n_max;
      s1_i_q     <= i_q;
      s1_j_q     <= j_q;
      s2_v_q     <= s1_v_q;
      prod_q     <= prod_d;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_i_q     <= s1_i_q;
      s2_j_q     <= s1_j_q;
      acc_v_q    <= s2_v_q;
      if (s2_v_q) acc_q <= acc_d;
      acc_last_q <= s2_last_q;
      acc_i_q    <= s2_i_q;
      acc_j_q    <= s2_j_q;
      if (acc_v_q && acc_last_q) c_q[acc_i_q][acc_j_q] <= wb_d;
    end
  end

  for (genvar gi = 0; gi < OUT_DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < OUT_DIM; gj++) begin : g_col
      assign c[gi][gj] = c_q[gi][gj];
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_conv2d_tile_engine.sv
// tb_conv2d_tile_engine: randomized jobs against an arithmetic reference model,
// with a scoreboard queue consumed by a monitor on every done pulse.
module tb_conv2d_tile_engine;

  localparam int D = 8, K = 3, O = 4, I = 6, ACCW = 24, OW = 16, LAT = 147;

  typedef logic [D-1:0]  tile_t [0:I-1][0:I-1];
  typedef logic [D-1:0]  kern_t [0:K-1][0:K-1];
  typedef logic [OW-1:0] res_t  [0:O-1][0:O-1];
  typedef struct { res_t px; int acc_cyc; int id; } exp_t;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic          signed_mode = 1'b0, relu_en = 1'b0;
  logic [4:0]    shift = '0;
  logic [D-1:0]  input_tile [0:I-1][0:I-1];
  logic [D-1:0]  kernel     [0:K-1][0:K-1];
  logic [OW-1:0] c_out      [0:O-1][0:O-1];
  logic          busy, done;

  int   checks = 0, errors = 0, cyc = 0, job_id = 0;
  exp_t exp_q [$];

  conv2d_tile_engine #(.DATA_W(D), .KSIZE(K), .OUT_DIM(O), .ACC_W(ACCW), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode), .relu_en(relu_en),
    .shift(shift), .input_tile(input_tile), .kernel(kernel), .c(c_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // Reference: direct convolution sum, then shift / ReLU / clamp with plain integers
  function automatic res_t model(input tile_t t, input kern_t k, input bit sg, input bit rl, input int sh);
    res_t   r;
    longint sum, v;
    for (int i = 0; i < O; i++)
      for (int j = 0; j < O; j++) begin
        sum = 0;
        for (int m = 0; m < K; m++)
          for (int n = 0; n < K; n++)
            if (sg) sum += longint'($signed(t[i+m][j+n])) * longint'($signed(k[m][n]));
            else    sum += longint'(t[i+m][j+n]) * longint'(k[m][n]);
        v = sum >>> sh;
        if (sg && rl && v < 0) v = 0;
        if (sg) begin
          if (v > 32767) v = 32767;
          if (v < -32768) v = -32768;
        end else if (v > 65535) v = 65535;
        r[i][j] = v[OW-1:0];
      end
    return r;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int r = 0; r < I; r++) for (int s = 0; s < I; s++) t[r][s] = D'($urandom_range(255));
    return t;
  endfunction

  function automatic kern_t rand_kern();
    kern_t k;
    for (int r = 0; r < K; r++) for (int s = 0; s < K; s++) k[r][s] = D'($urandom_range(255));
    return k;
  endfunction

  task automatic scramble_inputs();
    input_tile  = rand_tile();
    kernel      = rand_kern();
    signed_mode = 1'($urandom_range(1));
    relu_en     = 1'($urandom_range(1));
    shift       = 5'($urandom_range(31));
  endtask

  // Monitor: each done pops one expectation; also checks latency and pulse width
  initial begin
    exp_t e;
    bit   post_done = 0;
    int   bad;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        post_done = 0;
      end else begin
        if (post_done) begin
          chk("busy_after_done", longint'(busy), 0);
          chk("done_pulse_width", longint'(done), 0);
          post_done = 0;
        end
        if (done) begin
          post_done = 1;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            bad = errors;
            chk($sformatf("job%0d_latency", e.id), longint'(cyc - e.acc_cyc), LAT);
            chk($sformatf("job%0d_busy_at_done", e.id), longint'(busy), 1);
            for (int i = 0; i < O; i++)
              for (int j = 0; j < O; j++)
                chk($sformatf("job%0d_c[%0d][%0d]", e.id, i, j), longint'(c_out[i][j]), longint'(e.px[i][j]));
            $display("job %0d done at cycle %0d: c[0][0]=%0d c[3][3]=%0d, %0d new errors",
                     e.id, cyc, c_out[0][0], c_out[3][3], errors - bad);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    for (int n = 0; n < 500 && busy; n++) @(negedge clk);
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("done_timeout", longint'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  // Issue one job; optionally scramble inputs and poke start while it runs
  task automatic run_job(input tile_t t, input kern_t k, input bit sg, input bit rl, input int sh,
                         input bit scramble);
    exp_t e;
    wait_idle();
    @(negedge clk);
    input_tile = t; kernel = k; signed_mode = sg; relu_en = rl; shift = 5'(sh); start = 1'b1;
    @(posedge clk); #1;
    e.px = model(t, k, sg, rl, sh); e.acc_cyc = cyc; e.id = job_id++;
    exp_q.push_back(e);
    start = 1'b0;
    if (scramble) begin
      for (int n = 1; n <= 130; n++) begin
        @(negedge clk);
        scramble_inputs();
        start = (n == 10 || n == 100) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
    end
    wait_drain();
  endtask

  initial begin
    tile_t t;
    kern_t k;
    exp_t  e;
    int    a;
    input_tile = rand_tile();
    kernel     = rand_kern();
    repeat (3) @(negedge clk);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_done", longint'(done), 0);
    chk("reset_c00", longint'(c_out[0][0]), 0);
    chk("reset_c33", longint'(c_out[3][3]), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All ones -> 9 everywhere
    for (int r = 0; r < I; r++) for (int s = 0; s < I; s++) t[r][s] = 8'd1;
    for (int r = 0; r < K; r++) for (int s = 0; s < K; s++) k[r][s] = 8'd1;
    run_job(t, k, 0, 0, 0, 0);

    // Identity kernel picks tile[i+1][j+1]
    for (int r = 0; r < I; r++) for (int s = 0; s < I; s++) t[r][s] = D'(r * 6 + s);
    for (int r = 0; r < K; r++) for (int s = 0; s < K; s++) k[r][s] = 8'd0;
    k[1][1] = 8'd1;
    run_job(t, k, 0, 0, 0, 0);

    // Signed negative saturation, then ReLU
    for (int r = 0; r < I; r++) for (int s = 0; s < I; s++) t[r][s] = 8'h80;
    for (int r = 0; r < K; r++) for (int s = 0; s < K; s++) k[r][s] = 8'h7F;
    run_job(t, k, 1, 0, 0, 0);
    run_job(t, k, 1, 1, 0, 0);

    // Unsigned saturation, then shift brings it in range
    for (int r = 0; r < I; r++) for (int s = 0; s < I; s++) t[r][s] = 8'hFF;
    for (int r = 0; r < K; r++) for (int s = 0; s < K; s++) k[r][s] = 8'hFF;
    run_job(t, k, 0, 0, 0, 0);
    run_job(t, k, 0, 0, 4, 0);
    run_job(t, k, 0, 1, 0, 0);

    // Inputs churn and start pulses during RUN: snapshot must hold, no extra job
    run_job(rand_tile(), rand_kern(), 1, 0, 3, 1);
    run_job(rand_tile(), rand_kern(), 0, 0, 2, 1);

    // Random jobs
    for (int n = 0; n < 8; n++)
      run_job(rand_tile(), rand_kern(), 1'($urandom_range(1)), 1'($urandom_range(1)),
              int'($urandom_range(12)), 0);

    // Start held high: second job accepted on the first IDLE edge after DONE
    wait_idle();
    t = rand_tile(); k = rand_kern();
    @(negedge clk);
    input_tile = t; kernel = k; signed_mode = 1'b1; relu_en = 1'b0; shift = 5'd2; start = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    e.px = model(t, k, 1, 0, 2); e.acc_cyc = a; e.id = job_id++;
    exp_q.push_back(e);
    repeat (LAT + 2) @(posedge clk);
    #1;
    e.acc_cyc = a + LAT + 2; e.id = job_id++;
    exp_q.push_back(e);
    start = 1'b0;
    wait_drain();

    // Reset in the middle of a job aborts it
    wait_idle();
    @(negedge clk);
    input_tile = rand_tile(); kernel = rand_kern(); signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_busy", longint'(busy), 0);
    chk("midreset_done", longint'(done), 0);
    for (int i = 0; i < O; i++)
      for (int j = 0; j < O; j++) chk($sformatf("midreset_c[%0d][%0d]", i, j), longint'(c_out[i][j]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("after_abort_busy", longint'(busy), 0);
    $display("reset abort at cycle %0d handled", cyc);
    run_job(rand_tile(), rand_kern(), 1, 1, 1, 0);
    run_job(rand_tile(), rand_kern(), 0, 0, 0, 0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv2d_tile_engine.md
Name: conv2d_tile_engine

Overview:
Parametrised single-MAC 2-D convolution engine for the NPU datapath. It computes one OUT_DIM x OUT_DIM output tile from an IN_DIM x IN_DIM input tile and a KSIZE x KSIZE kernel. Beyond a fixed 3x3 unsigned convolver, it adds signed/unsigned mode, a requantising right-shift, optional ReLU, output saturation, and a start/busy/done handshake with an operand snapshot. It sits between the tile buffer and the output scratchpad.

Parameters:
DATA_W, 8, input and kernel element width
KSIZE, 3, kernel edge length (>=1)
OUT_DIM, 4, output tile edge length (>=1)
IN_DIM, OUT_DIM+KSIZE-1, input tile edge length; derived, never overridden
ACC_W, 24, accumulator width; must be >= 2*DATA_W + clog2(KSIZE*KSIZE) + 1
OUT_W, 16, output element width (<= ACC_W)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job request; accepted only in IDLE
signed_mode  in  1  1 = operands and result are two's complement; sampled at accept
relu_en  in  1  clamp negative results to 0; sampled at accept
shift  in  5  arithmetic right shift applied to the accumulator before saturation; sampled at accept
input_tile  in  DATA_W  unpacked [0:IN_DIM-1][0:IN_DIM-1]; input elements
kernel  in  DATA_W  unpacked [0:KSIZE-1][0:KSIZE-1]; kernel elements
c  out  OUT_W  unpacked [0:OUT_DIM-1][0:OUT_DIM-1]; result tile
busy  out  1  job in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, all c=0, counters/accumulator/pipeline cleared. Reset mid-job aborts the job; no done pulse; c returns to 0.
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 at a clock edge accepts the job. At that edge, input_tile, kernel, signed_mode, relu_en and shift are snapshotted into internal registers. Inputs may change freely afterwards. Next state is RUN, busy=1.
- RUN: issues one operand pair per cycle in raster order: output row i, output col j, kernel row m, kernel col n, with n fastest. Operand pair = snap_tile[i+m][j+n] x snap_kernel[m][n]. Total issue = OUT_DIM^2*KSIZE^2 cycles. After the final issue, go to DRAIN.
- Pipeline: stage 1 registers the operands; stage 2 registers the product (2*DATA_W bits, sign- or zero-extended per mode); stage 3 accumulates into ACC_W bits. The accumulator loads (does not add) on the product with m=n=0.
- Pixel writeback: when the product with m=n=KSIZE-1 is accumulated, the final sum is processed: arithmetic shift (logical in unsigned mode) by shift, then ReLU if relu_en and signed_mode, then saturation. c[i][j] is registered on the following edge. Other c entries hold their values.
- Saturation: signed clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; unsigned clamps to [0, 2^OUT_W-1]. relu_en is ignored in unsigned mode.
- DRAIN: waits for the pipeline to empty and the last c write, then goes to DONE.
- DONE: lasts exactly one cycle with done=1 and busy=1. All c are final in this cycle. Next state is IDLE.
- Latency: the accept edge is cycle 0. done is high during cycle OUT_DIM^2*KSIZE^2+3 (147 with defaults).
- start while busy (RUN/DRAIN/DONE) is ignored and not queued. start held high continuously begins a new job on the first IDLE cycle.
- c holds its last values between jobs. A new job overwrites pixels progressively in raster order.
- No combinational path from any input to any output.

Test Plan:
- Unsigned, shift=0, tile all 1, kernel all 1, start pulsed -> every c=9; done a single pulse exactly 147 cycles after the accept edge; busy low the cycle after.
- Unsigned identity kernel (only kernel[1][1]=1), tile[r][s]=r*6+s -> c[i][j]=tile[i+1][j+1], e.g. c[0][0]=7, c[3][3]=28.
- Signed, tile all 0x80 (-128), kernel all 0x7F -> sum -146304 saturates to c=0x8000. Same job with relu_en=1 -> all c=0.
- Unsigned, tile all 0xFF, kernel all 0xFF -> sum 585225 saturates to c=0xFFFF. Same job with shift=4 -> c=36576 (0x8EE0).
- Change input_tile and kernel every cycle after accept, and pulse start during RUN -> results equal the snapshot values; no second job; exactly one done pulse.
- Assert rst_n=0 for 2 cycles at cycle 50 of a job -> c all 0, busy=0, no done. A new start afterwards completes normally with the correct values.
